// File: rtl/nibble_pkg.sv
// Shared widths and assembler state encoding for the nibble packer and its byte FIFO.
package nibble_pkg;
   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;

   typedef enum logic {
      ASM_EMPTY = 1'b0,
      ASM_HALF  = 1'b1
   } asm_state_e;

   function automatic logic [BYTE_W-1:0] pack_byte(input logic [NIB_W-1:0] hi,
                                                   input logic [NIB_W-1:0] lo);
      return {hi, lo};
   endfunction
endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered head, occupancy count and full flag; the caller
// guarantees push is only asserted when there is room (or a pop frees a slot).
module byte_fifo
   import nibble_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [BYTE_W-1:0] push_data,
   input  logic              pop,
   output logic [BYTE_W-1:0] head,
   output logic [CW-1:0]     count,
   output logic              full
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [BYTE_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              pop_ok;

   assign pop_ok = pop && (count_q != '0);

   // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == FULL_CNT);

endmodule

// File: rtl/nibble_packer.sv
// Pairs strobed nibbles into bytes (first nibble in the high half), with flush
// of a pending half-byte, and buffers them for a valid/ready consumer.
module nibble_packer
   import nibble_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NIB_W-1:0]  nib_in,
   input  logic              nib_valid,
   input  logic              flush,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              full,
   output logic              overflow,
   output logic [CW-1:0]     count
);

   asm_state_e        state_q, state_d;
   logic [NIB_W-1:0]  hi_q, hi_d;
   logic              overflow_q, overflow_d;
   logic              push_req;
   logic [BYTE_W-1:0] push_byte;
   logic              push_ok;
   logic              pop;
   logic              fifo_full;
   logic [CW-1:0]     fifo_count;

   // byte_valid/byte_ready: a byte transfers on every rising edge where both are
   // high; byte_valid comes only from registered occupancy, never from byte_ready.
   assign byte_valid = (fifo_count != '0);
   assign pop        = byte_valid && byte_ready;
   assign push_ok    = push_req && (!fifo_full || pop);

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      push_req  = 1'b0;
      push_byte = '0;
      case (state_q)
         ASM_EMPTY: begin
            if (nib_valid) begin
               hi_d    = nib_in;
               state_d = ASM_HALF;
            end
         end
         ASM_HALF: begin
            // A strobe wins over a same-cycle flush, so no padded byte is made.
            if (nib_valid) begin
               push_req  = 1'b1;
               push_byte = pack_byte(hi_q, nib_in);
               state_d   = ASM_EMPTY;
            end else if (flush) begin
               push_req  = 1'b1;
               push_byte = pack_byte(hi_q, '0);
               state_d   = ASM_EMPTY;
            end
         end
         default: state_d = ASM_EMPTY;
      endcase
      overflow_d = overflow_q | (push_req && !push_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ASM_EMPTY;
         hi_q       <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         overflow_q <= overflow_d;
      end
   end

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_ok),
      .push_data (push_byte),
      .pop       (pop),
      .head      (byte_out),
      .count     (fifo_count),
      .full      (fifo_full)
   );

   assign full     = fifo_full;
   assign count    = fifo_count;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: pairing, flush, overflow, full-with-pop and async reset.
module tb_nibble_packer;
   import nibble_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic              clk;
   logic              rst_n;
   logic [NIB_W-1:0]  nib_in;
   logic              nib_valid;
   logic              flush;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_valid;
   logic              byte_ready;
   logic              full;
   logic              overflow;
   logic [CW-1:0]     count;

   int n_checks = 0;
   int n_err    = 0;
   logic [BYTE_W-1:0] exp_q[$];

   nibble_packer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .nib_in     (nib_in),
      .nib_valid  (nib_valid),
      .flush      (flush),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .full       (full),
      .overflow   (overflow),
      .count      (count)
   );

   // clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drivers: called at a falling edge, return at the next falling edge
   task automatic send_nib(input logic [3:0] v);
      nib_in    = v;
      nib_valid = 1'b1;
      @(negedge clk);
      nib_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit expect_kept);
      send_nib(b[7:4]);
      send_nib(b[3:0]);
      if (expect_kept) exp_q.push_back(b);
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
   endtask

   // scoreboard drain: compares each head against the expected queue
   task automatic drain(input int n);
      logic [7:0] e;
      byte_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         chk("drain_valid", {7'd0, byte_valid}, 8'h01);
         chk("drain_data", byte_out, e);
         @(negedge clk);
      end
      byte_ready = 1'b0;
      chk("drain_empty", {7'd0, byte_valid}, 8'h00);
   endtask

   initial begin
      nib_in     = '0;
      nib_valid  = 1'b0;
      flush      = 1'b0;
      byte_ready = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_valid", {7'd0, byte_valid}, 8'h00);
      chk("rst_full", {7'd0, full}, 8'h00);
      chk("rst_ovf", {7'd0, overflow}, 8'h00);
      chk("rst_count", 8'(count), 8'h00);
      chk("rst_byte", byte_out, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // A then 5 with consumer ready
      byte_ready = 1'b1;
      send_nib(4'hA);
      chk("half_no_valid", {7'd0, byte_valid}, 8'h00);
      send_nib(4'h5);
      chk("a5_valid", {7'd0, byte_valid}, 8'h01);
      chk("a5_data", byte_out, 8'hA5);
      @(negedge clk);
      chk("a5_popped", {7'd0, byte_valid}, 8'h00);
      chk("a5_count", 8'(count), 8'h00);
      byte_ready = 1'b0;

      // fill past depth with consumer stalled
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      chk("fill3_full", {7'd0, full}, 8'h00);
      send_byte(8'h44, 1'b1);
      chk("fill4_full", {7'd0, full}, 8'h01);
      chk("fill4_count", 8'(count), 8'h04);
      chk("fill4_ovf", {7'd0, overflow}, 8'h00);
      send_byte(8'h55, 1'b0);
      chk("ovf_set", {7'd0, overflow}, 8'h01);
      chk("ovf_count", 8'(count), 8'h04);
      drain(4);
      chk("ovf_sticky", {7'd0, overflow}, 8'h01);

      // flush a pending high nibble, then flush with nothing pending
      send_nib(4'h7);
      do_flush();
      exp_q.push_back(8'h70);
      chk("flush_count", 8'(count), 8'h01);
      do_flush();
      chk("flush_empty_count", 8'(count), 8'h01);
      drain(1);

      // strobe and flush together: only the real byte
      send_nib(4'h3);
      nib_in    = 4'h9;
      nib_valid = 1'b1;
      flush     = 1'b1;
      @(negedge clk);
      nib_valid = 1'b0;
      flush     = 1'b0;
      exp_q.push_back(8'h39);
      @(negedge clk);
      chk("prio_count", 8'(count), 8'h01);
      drain(1);

      // push and pop in the same cycle while full
      do_reset();
      send_byte(8'hA1, 1'b1);
      send_byte(8'hB2, 1'b1);
      send_byte(8'hC3, 1'b1);
      send_byte(8'hD4, 1'b1);
      send_nib(4'hE);
      chk("pp_full", {7'd0, full}, 8'h01);
      chk("pp_head", byte_out, exp_q.pop_front());
      nib_in     = 4'h5;
      nib_valid  = 1'b1;
      byte_ready = 1'b1;
      @(negedge clk);
      nib_valid = 1'b0;
      exp_q.push_back(8'hE5);
      chk("pp_count", 8'(count), 8'h04);
      chk("pp_ovf", {7'd0, overflow}, 8'h00);
      drain(4);

      // asynchronous reset mid-operation
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_nib(4'h6);
      chk("pre_rst_count", 8'(count), 8'h02);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {7'd0, byte_valid}, 8'h00);
      chk("arst_count", 8'(count), 8'h00);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'hCD, 1'b1);
      chk("post_rst_count", 8'(count), 8'h01);
      drain(1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
